uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART byte transmitter among `NUM_REQ` byte producers. Each producer raises a request with a byte. The arbiter grants one producer at a time, optionally lets it stream a bounded burst, and hands each byte to the serializer over a valid/ready handshake. It sits between producer logic (test pattern generators, status reporters) and the UART serializer that drives `ftdi_tx`.

---
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte serializer among NUM_REQ producers, with bounded bursts.
// Optional per-grant tag byte (8'hF0 | index) enabled by defining UART_ARB_TAG_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_valid,
  input  logic                 i_tx_ready,
  output logic                 o_busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
`ifdef UART_ARB_TAG_EN
    S_GAP  = 2'd2,
    S_TAG  = 2'd3
`else
    S_GAP  = 2'd2
`endif
  } state_t;

  state_t             r_state;
  logic [IW-1:0]      r_last;
  logic [IW-1:0]      r_gidx;
  logic [NUM_REQ-1:0] r_grant;
  logic [7:0]         r_tx_data;
  logic               r_tx_valid;
  logic [3:0]         r_count;
`ifdef UART_ARB_TAG_EN
  logic [7:0]         r_data;
`endif

  logic [7:0]         w_bytes [NUM_REQ];
  logic               w_any;
  logic [IW-1:0]      w_pick;
  logic [NUM_REQ-1:0] w_pick_onehot;
  int                 w_idx;
  logic [IW-1:0]      w_sel;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
    assign w_bytes[gi] = i_req_data[8*gi +: 8];
  end

  // Scan from the far end down so the nearest index after r_last wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = 0;
    w_sel  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = (int'(r_last) + k) % NUM_REQ;
      w_sel = IW'(w_idx);
      if (i_req[w_sel]) begin
        w_any  = 1'b1;
        w_pick = w_sel;
      end
    end
  end

  always_comb begin
    w_pick_onehot         = '0;
    w_pick_onehot[w_pick] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_last     <= IW'(NUM_REQ - 1);
      r_gidx     <= '0;
      r_grant    <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_count    <= 4'd0;
`ifdef UART_ARB_TAG_EN
      r_data     <= 8'h00;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gidx     <= w_pick;
            r_grant    <= w_pick_onehot;
            r_count    <= 4'd1;
            r_tx_valid <= 1'b1;
`ifdef UART_ARB_TAG_EN
            r_tx_data  <= 8'hF0 | 8'(w_pick);
            r_data     <= w_bytes[w_pick];
            r_state    <= S_TAG;
`else
            r_tx_data  <= w_bytes[w_pick];
            r_state    <= S_SEND;
`endif
          end
        end
`ifdef UART_ARB_TAG_EN
        S_TAG: begin
          if (i_tx_ready) begin
            r_tx_data <= r_data;
            r_state   <= S_SEND;
          end
        end
`endif
        S_SEND: begin
          if (i_tx_ready) begin
            r_tx_valid <= 1'b0;
            r_state    <= S_GAP;
          end
        end
        S_GAP: begin
          // Priority pointer moves only when the grant ends, never mid-burst.
          if (i_req[r_gidx] && (r_count < 4'(MAX_BURST))) begin
            r_tx_data  <= w_bytes[r_gidx];
            r_count    <= r_count + 4'd1;
            r_tx_valid <= 1'b1;
            r_state    <= S_SEND;
          end else begin
            r_last  <= r_gidx;
            r_grant <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Reset drops the in-flight byte, so it must not be acknowledged.
  assign o_ack      = ((r_state == S_SEND) && i_tx_ready && !i_rst) ? r_grant : '0;
  assign o_grant    = r_grant;
  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;
  assign o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queue-based producers and serializer,
// expected transfer order computed from round-robin/burst rules on the producer queues.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int MB = 4;

  logic          clk;
  logic          rst;
  logic [NR-1:0] req;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] ack;
  logic [NR-1:0] grant;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_data(req_data),
    .o_ack(ack), .o_grant(grant), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
    .i_tx_ready(tx_ready), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]    mem [NR][16];
  int            head [NR];
  int            len  [NR];
  logic [7:0]    exp_byte [$];
  logic [NR-1:0] exp_ack [$];
  logic [NR-1:0] exp_grant [$];
  logic [7:0]    obs_byte [$];
  logic [NR-1:0] obs_ack [$];
  logic [NR-1:0] obs_grant [$];
  int proto_err, timed_out, first_valid_n, m_last;
  int n_cmp, n_bad;

  task automatic clear_queues();
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      len[i]  = 0;
    end
  endtask

  task automatic push_byte(input int r, input logic [7:0] b);
    mem[r][len[r]] = b;
    len[r]++;
  endtask

  task automatic drive_producers();
    for (int i = 0; i < NR; i++) begin
      req[i] = (head[i] < len[i]);
      req_data[8*i +: 8] = (head[i] < len[i]) ? mem[i][head[i]] : 8'h00;
    end
  endtask

  function automatic bit pending();
    bit p;
    p = 1'b0;
    for (int i = 0; i < NR; i++) if (head[i] < len[i]) p = 1'b1;
    return p;
  endfunction

  // Reference: grants go round-robin after m_last to non-empty queues, each taking up to MB bytes.
  task automatic build_expected();
    int ptr [NR];
    int g;
    bit done;
    logic [NR-1:0] oh;
    exp_byte.delete(); exp_ack.delete(); exp_grant.delete();
    for (int i = 0; i < NR; i++) ptr[i] = head[i];
    done = 1'b0;
    while (!done) begin
      g = -1;
      for (int k = 1; k <= NR; k++)
        if (g < 0 && ptr[(m_last + k) % NR] < len[(m_last + k) % NR]) g = (m_last + k) % NR;
      if (g < 0) done = 1'b1;
      else begin
        oh = '0;
        oh[g] = 1'b1;
`ifdef UART_ARB_TAG_EN
        exp_byte.push_back(8'hF0 | 8'(g)); exp_ack.push_back('0); exp_grant.push_back(oh);
`endif
        for (int c = 0; c < MB && ptr[g] < len[g]; c++) begin
          exp_byte.push_back(mem[g][ptr[g]]); exp_ack.push_back(oh); exp_grant.push_back(oh);
          ptr[g]++;
        end
        m_last = g;
      end
    end
  endtask

  // Producers pop on ack; serializer ready is random with the given percentage.
  task automatic run_traffic(input int ready_pct, input int budget);
    int n;
    bit stall;
    logic [7:0] held;
    logic [NR-1:0] ackd;
    obs_byte.delete(); obs_ack.delete(); obs_grant.delete();
    proto_err = 0; timed_out = 0; first_valid_n = -1;
    n = 0; stall = 1'b0; held = 8'h00;
    drive_producers();
    while ((pending() || busy === 1'b1) && n < budget) begin
      @(negedge clk);
      tx_ready = (int'($urandom_range(0, 99)) < ready_pct);
      #1;
      if (tx_valid === 1'b1 && first_valid_n < 0) first_valid_n = n;
      if (ack !== '0 && !(tx_valid === 1'b1 && tx_ready)) proto_err++;
      if (stall && (tx_valid !== 1'b1 || tx_data !== held)) proto_err++;
      if (tx_valid === 1'b1 && tx_ready) begin
        obs_byte.push_back(tx_data); obs_ack.push_back(ack); obs_grant.push_back(grant);
      end
      stall = (tx_valid === 1'b1 && !tx_ready);
      held  = tx_data;
      ackd  = ack;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) if (ackd[i] === 1'b1 && head[i] < len[i]) head[i]++;
      drive_producers();
      n++;
    end
    tx_ready = 1'b0;
    if (n >= budget) timed_out = 1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; req_data = '0; tx_ready = 1'b0;
    clear_queues();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_last = NR - 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({tx_valid, tx_data, ack, grant, busy} !== {1'b0, 8'h00, 4'h0, 4'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b d=%h ack=%b gnt=%b busy=%b want all zero",
               tx_valid, tx_data, ack, grant, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    push_byte(2, 8'h41);
    build_expected();
    run_traffic(100, 100);
    n_cmp++;
    if (first_valid_n !== 1) begin
      n_bad++; $display("FAIL single_latency: got %0d want 1", first_valid_n);
    end
    n_cmp++;
    if (obs_byte.size() !== exp_byte.size()) begin
      n_bad++; $display("FAIL single_count: got %0d want %0d", obs_byte.size(), exp_byte.size());
    end
    for (int i = 0; i < exp_byte.size() && i < obs_byte.size(); i++) begin
      n_cmp++;
      if ({obs_byte[i], obs_ack[i], obs_grant[i]} !== {exp_byte[i], exp_ack[i], exp_grant[i]}) begin
        n_bad++;
        $display("FAIL single_xfer[%0d]: got d=%h ack=%b gnt=%b want d=%h ack=%b gnt=%b", i,
                 obs_byte[i], obs_ack[i], obs_grant[i], exp_byte[i], exp_ack[i], exp_grant[i]);
      end
    end
`ifndef UART_ARB_TAG_EN
    n_cmp++;
    if (obs_byte.size() < 1 || obs_byte[0] !== 8'h41 || obs_ack[0] !== 4'b0100) begin
      n_bad++; $display("FAIL single_literal: got size %0d want one 41 with ack 0100", obs_byte.size());
    end
`endif
    n_cmp++;
    if (proto_err !== 0 || timed_out !== 0 || grant !== 4'h0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_end: got perr=%0d tmo=%0d gnt=%b busy=%b want 0/0/0000/0",
               proto_err, timed_out, grant, busy);
    end
  endtask

  task automatic test_contention();
    do_reset();
    for (int round = 0; round < 2; round++) begin
      for (int r = 0; r < NR; r++) push_byte(r, 8'h10 + 8'(r));
      build_expected();
      run_traffic(round == 0 ? 100 : 70, 400);
      n_cmp++;
      if (obs_byte.size() !== exp_byte.size() || proto_err !== 0 || timed_out !== 0) begin
        n_bad++;
        $display("FAIL contention_r%0d: got n=%0d perr=%0d tmo=%0d want n=%0d perr=0 tmo=0",
                 round, obs_byte.size(), proto_err, timed_out, exp_byte.size());
      end
      for (int i = 0; i < exp_byte.size() && i < obs_byte.size(); i++) begin
        n_cmp++;
        if ({obs_byte[i], obs_ack[i], obs_grant[i]} !== {exp_byte[i], exp_ack[i], exp_grant[i]}) begin
          n_bad++;
          $display("FAIL contention_r%0d[%0d]: got d=%h ack=%b gnt=%b want d=%h ack=%b gnt=%b", round, i,
                   obs_byte[i], obs_ack[i], obs_grant[i], exp_byte[i], exp_ack[i], exp_grant[i]);
        end
      end
    end
  endtask

  task automatic test_burst_cap();
    logic [7:0] lit [7];
    do_reset();
    for (int i = 0; i < 6; i++) push_byte(1, 8'hA0 + 8'(i));
    push_byte(3, 8'h33);
    lit[0] = 8'hA0; lit[1] = 8'hA1; lit[2] = 8'hA2; lit[3] = 8'hA3;
    lit[4] = 8'h33; lit[5] = 8'hA4; lit[6] = 8'hA5;
    build_expected();
    run_traffic(100, 400);
    n_cmp++;
    if (obs_byte.size() !== exp_byte.size() || proto_err !== 0 || timed_out !== 0) begin
      n_bad++;
      $display("FAIL burst_count: got n=%0d perr=%0d tmo=%0d want n=%0d perr=0 tmo=0",
               obs_byte.size(), proto_err, timed_out, exp_byte.size());
    end
    for (int i = 0; i < exp_byte.size() && i < obs_byte.size(); i++) begin
      n_cmp++;
      if ({obs_byte[i], obs_ack[i], obs_grant[i]} !== {exp_byte[i], exp_ack[i], exp_grant[i]}) begin
        n_bad++;
        $display("FAIL burst_xfer[%0d]: got d=%h ack=%b gnt=%b want d=%h ack=%b gnt=%b", i,
                 obs_byte[i], obs_ack[i], obs_grant[i], exp_byte[i], exp_ack[i], exp_grant[i]);
      end
    end
`ifndef UART_ARB_TAG_EN
    for (int i = 0; i < 7 && i < obs_byte.size(); i++) begin
      n_cmp++;
      if (obs_byte[i] !== lit[i]) begin
        n_bad++; $display("FAIL burst_literal[%0d]: got %h want %h", i, obs_byte[i], lit[i]);
      end
    end
`endif
  endtask

  task automatic test_backpressure();
    do_reset();
    push_byte(0, 8'h5A);
    drive_producers();
    tx_ready = 1'b0;
    @(posedge clk); #1;
`ifdef UART_ARB_TAG_EN
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
`endif
    for (int c = 0; c < 20; c++) begin
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h5A || ack !== 4'h0) begin
        n_bad++;
        $display("FAIL stall_cycle[%0d]: got v=%b d=%h ack=%b want v=1 d=5a ack=0000", c, tx_valid, tx_data, ack);
      end
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    #1;
    n_cmp++;
    if (ack !== 4'b0001 || tx_valid !== 1'b1) begin
      n_bad++; $display("FAIL stall_release_ack: got ack=%b v=%b want ack=0001 v=1", ack, tx_valid);
    end
    @(posedge clk); #1;
    head[0]++;
    drive_producers();
    tx_ready = 1'b0;
    n_cmp++;
    if (tx_valid !== 1'b0 || ack !== 4'h0) begin
      n_bad++; $display("FAIL stall_gap: got v=%b ack=%b want v=0 ack=0000", tx_valid, ack);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || grant !== 4'h0) begin
      n_bad++; $display("FAIL stall_idle: got busy=%b gnt=%b want 0/0000", busy, grant);
    end
  endtask

  task automatic test_reset_mid_send();
    do_reset();
    for (int r = 0; r < NR; r++) push_byte(r, 8'h20 + 8'(r));
    drive_producers();
    tx_ready = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (grant !== 4'b0001 || tx_valid !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_pre: got gnt=%b v=%b want 0001/1", grant, tx_valid);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (ack !== 4'h0) begin
      n_bad++; $display("FAIL rstmid_ack: got %b want 0000", ack);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (tx_valid !== 1'b0 || grant !== 4'h0 || busy !== 1'b0 || ack !== 4'h0) begin
      n_bad++;
      $display("FAIL rstmid_after: got v=%b gnt=%b busy=%b ack=%b want 0/0000/0/0000", tx_valid, grant, busy, ack);
    end
    rst = 1'b0;
    m_last = NR - 1;
    build_expected();
    run_traffic(100, 400);
    n_cmp++;
    if (obs_byte.size() !== exp_byte.size() || proto_err !== 0 || timed_out !== 0 ||
        obs_grant.size() < 1 || obs_grant[0] !== 4'b0001) begin
      n_bad++;
      $display("FAIL rstmid_resume: got n=%0d perr=%0d tmo=%0d want n=%0d first grant 0001",
               obs_byte.size(), proto_err, timed_out, exp_byte.size());
    end
    for (int i = 0; i < exp_byte.size() && i < obs_byte.size(); i++) begin
      n_cmp++;
      if ({obs_byte[i], obs_ack[i], obs_grant[i]} !== {exp_byte[i], exp_ack[i], exp_grant[i]}) begin
        n_bad++;
        $display("FAIL rstmid_xfer[%0d]: got d=%h ack=%b gnt=%b want d=%h ack=%b gnt=%b", i,
                 obs_byte[i], obs_ack[i], obs_grant[i], exp_byte[i], exp_ack[i], exp_grant[i]);
      end
    end
  endtask

`ifdef UART_ARB_TAG_EN
  task automatic test_tag();
    do_reset();
    push_byte(2, 8'h55);
    push_byte(2, 8'h56);
    run_traffic(100, 100);
    n_cmp++;
    if (obs_byte.size() !== 3) begin
      n_bad++; $display("FAIL tag_count: got %0d want 3", obs_byte.size());
    end else begin
      n_cmp++;
      if ({obs_byte[0], obs_byte[1], obs_byte[2]} !== {8'hF2, 8'h55, 8'h56} ||
          {obs_ack[0], obs_ack[1], obs_ack[2]} !== {4'b0000, 4'b0100, 4'b0100}) begin
        n_bad++;
        $display("FAIL tag_seq: got %h %h %h acks %b %b %b want f2 55 56 acks 0000 0100 0100",
                 obs_byte[0], obs_byte[1], obs_byte[2], obs_ack[0], obs_ack[1], obs_ack[2]);
      end
    end
    m_last = 2;
  endtask
`endif

  task automatic test_random();
    int pct;
    for (int it = 0; it < 8; it++) begin
      clear_queues();
      for (int r = 0; r < NR; r++) begin
        int l;
        l = int'($urandom_range(0, 6));
        for (int b = 0; b < l; b++) push_byte(r, 8'($urandom()));
      end
      pct = int'($urandom_range(25, 100));
      build_expected();
      run_traffic(pct, 3000);
      n_cmp++;
      if (obs_byte.size() !== exp_byte.size() || proto_err !== 0 || timed_out !== 0) begin
        n_bad++;
        $display("FAIL random_%0d: got n=%0d perr=%0d tmo=%0d want n=%0d perr=0 tmo=0",
                 it, obs_byte.size(), proto_err, timed_out, exp_byte.size());
      end
      for (int i = 0; i < exp_byte.size() && i < obs_byte.size(); i++) begin
        n_cmp++;
        if ({obs_byte[i], obs_ack[i], obs_grant[i]} !== {exp_byte[i], exp_ack[i], exp_grant[i]}) begin
          n_bad++;
          $display("FAIL random_%0d[%0d]: got d=%h ack=%b gnt=%b want d=%h ack=%b gnt=%b", it, i,
                   obs_byte[i], obs_ack[i], obs_grant[i], exp_byte[i], exp_ack[i], exp_grant[i]);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; req = '0; req_data = '0; tx_ready = 1'b0;
    m_last = NR - 1;
    test_reset();
    test_single();
    test_contention();
    test_burst_cap();
    test_backpressure();
    test_reset_mid_send();
`ifdef UART_ARB_TAG_EN
    test_tag();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
